// File: rtl/pipeline_stall_ctrl_if.sv
// Data-memory handshake between the pipeline stall controller and the
// EX/MEM-side memory port.
//   exmem_memreq : instruction in EX/MEM is a load or store
//   dmem_ack     : data memory completes the access this cycle
//   dmem_req     : request to data memory
// master = stall controller (drives dmem_req); slave = memory/pipe side.
interface pipeline_stall_ctrl_if;
    logic exmem_memreq;
    logic dmem_ack;
    logic dmem_req;

    modport master (input exmem_memreq, input dmem_ack, output dmem_req);
    modport slave  (output exmem_memreq, output dmem_ack, input dmem_req);
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Merges the load-use hazard, the ID-stage taken-branch flush and the
// multi-cycle dmem handshake into per-stage stall/bubble/flush controls.
// Ports:
//   clk_i, rst_i (async, active-low)
//   dmem_if        : dmem handshake (memreq/ack in, req out)
//   load_use_i     : load-use hazard from the hazard unit
//   branch_taken_i : branch/jump resolved taken in ID
//   *_stall_o      : hold PC, IF/ID, ID/EX, EX/MEM
//   *_bubble_o     : NOP control into ID/EX, MEM/WB
//   ifid_flush_o   : clear IF/ID
//   mem_timeout_o  : sticky dmem timeout error
//   stall_cnt_o / flush_cnt_o : saturating performance counters
module pipeline_stall_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    pipeline_stall_ctrl_if.master       dmem_if,
    input  logic                        load_use_i,
    input  logic                        branch_taken_i,
    output logic                        pc_stall_o,
    output logic                        ifid_stall_o,
    output logic                        idex_stall_o,
    output logic                        exmem_stall_o,
    output logic                        idex_bubble_o,
    output logic                        memwb_bubble_o,
    output logic                        ifid_flush_o,
    output logic                        mem_timeout_o,
    output logic [CNT_W-1:0]            stall_cnt_o,
    output logic [CNT_W-1:0]            flush_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;

    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_stall;

    // dmem request FSM
    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        mem_timeout_d    = mem_timeout_q;
        mem_stall        = 1'b0;
        dmem_if.dmem_req = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_if.dmem_req = dmem_if.exmem_memreq;
                // An ack in the request cycle is a zero-wait access: no stall.
                if (dmem_if.exmem_memreq && !dmem_if.dmem_ack) begin
                    mem_stall  = 1'b1;
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                dmem_if.dmem_req = 1'b1;
                // Stall drops in the ack cycle so the pipe advances on that edge.
                if (dmem_if.dmem_ack) begin
                    state_d = IDLE;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d       = ERR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            ERR: begin
                // Pipe frozen until reset; no further memory requests.
                mem_stall = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-stage controls. Priority: memory stall > load-use > taken branch.
    always_comb begin
        pc_stall_o     = 1'b0;
        ifid_stall_o   = 1'b0;
        idex_stall_o   = 1'b0;
        exmem_stall_o  = 1'b0;
        idex_bubble_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        ifid_flush_o   = 1'b0;
        if (mem_stall) begin
            pc_stall_o     = 1'b1;
            ifid_stall_o   = 1'b1;
            idex_stall_o   = 1'b1;
            exmem_stall_o  = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (load_use_i) begin
            // A pending branch waits for the forwarded load result.
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall_o && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush_o && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout_o = mem_timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
